// File: rtl/hram_arbiter.sv
`timescale 1ns/1ps
// Two-port arbiter sharing one hyper_xface; fixed priority, or round-robin when HRAM_ARB_RR_EN is defined.
// Latency: grant sampled in IDLE, ack + xf request pulse next cycle, done in first IDLE cycle after completion.
// Backpressure: requests are level-held and sampled only in IDLE; while busy they simply stay pending.
module hram_arbiter #(
    parameter int unsigned START_TIMEOUT = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        rq0_rd_req_i,
    input  logic        rq0_wr_req_i,
    input  logic [31:0] rq0_addr_i,
    input  logic [31:0] rq0_wr_d_i,
    input  logic        rq1_rd_req_i,
    input  logic        rq1_wr_req_i,
    input  logic [31:0] rq1_addr_i,
    input  logic [31:0] rq1_wr_d_i,
    output logic        rq0_ack_o,
    output logic        rq1_ack_o,
    output logic        rq0_done_o,
    output logic        rq1_done_o,
    output logic        rq0_rd_vld_o,
    output logic        rq1_rd_vld_o,
    output logic [31:0] rq_rd_d_o,
    output logic        xf_rd_req_o,
    output logic        xf_wr_req_o,
    output logic [31:0] xf_addr_o,
    output logic [31:0] xf_wr_d_o,
    input  logic        xf_busy_i,
    input  logic        xf_rd_rdy_i,
    input  logic [31:0] xf_rd_d_i,
    output logic        arb_busy_o,
    output logic        owner_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

    localparam logic [3:0] TO_LAST = 4'(START_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        op_wr_q, op_wr_d;
    logic        owner_q, owner_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [31:0] rd_d_q, rd_d_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  ack_q, ack_d;
    logic [1:0]  done_q, done_d;
    logic [1:0]  vld_q, vld_d;
    logic        xf_rd_req_q, xf_rd_req_d;
    logic        xf_wr_req_q, xf_wr_req_d;
    logic        arb_busy_q, arb_busy_d;

    logic pend0, pend1, gnt1;

    always_comb begin
        pend0 = rq0_rd_req_i | rq0_wr_req_i;
        pend1 = rq1_rd_req_i | rq1_wr_req_i;
`ifdef HRAM_ARB_RR_EN
        // On contention the port that did not win last time goes next.
        gnt1 = pend1 & (~pend0 | ~owner_q);
`else
        gnt1 = pend1 & ~pend0;
`endif
    end

    always_comb begin
        state_d     = state_q;
        op_wr_d     = op_wr_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wdat_d      = wdat_q;
        rd_d_d      = rd_d_q;
        cnt_d       = cnt_q;
        ack_d       = 2'b00;
        done_d      = 2'b00;
        vld_d       = 2'b00;
        xf_rd_req_d = 1'b0;
        xf_wr_req_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend0 | pend1) begin
                    owner_d       = gnt1;
                    addr_d        = gnt1 ? rq1_addr_i : rq0_addr_i;
                    wdat_d        = gnt1 ? rq1_wr_d_i : rq0_wr_d_i;
                    // A port raising both requests gets the write; the read is re-presented later.
                    op_wr_d       = gnt1 ? rq1_wr_req_i : rq0_wr_req_i;
                    ack_d[gnt1]   = 1'b1;
                    xf_wr_req_d   = op_wr_d;
                    xf_rd_req_d   = ~op_wr_d;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = 4'd0;
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (xf_busy_i) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == TO_LAST) begin
                    // Controller never went busy: treat the access as finished.
                    done_d[owner_q] = 1'b1;
                    state_d         = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WAIT_DONE: begin
                if (!xf_busy_i) begin
                    done_d[owner_q] = 1'b1;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_q == WAIT_START || state_q == WAIT_DONE) && !op_wr_q && xf_rd_rdy_i) begin
            rd_d_d         = xf_rd_d_i;
            vld_d[owner_q] = 1'b1;
        end

        arb_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            op_wr_q     <= 1'b0;
            owner_q     <= 1'b1;
            addr_q      <= '0;
            wdat_q      <= '0;
            rd_d_q      <= '0;
            cnt_q       <= '0;
            ack_q       <= '0;
            done_q      <= '0;
            vld_q       <= '0;
            xf_rd_req_q <= 1'b0;
            xf_wr_req_q <= 1'b0;
            arb_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_wr_q     <= op_wr_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wdat_q      <= wdat_d;
            rd_d_q      <= rd_d_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
            vld_q       <= vld_d;
            xf_rd_req_q <= xf_rd_req_d;
            xf_wr_req_q <= xf_wr_req_d;
            arb_busy_q  <= arb_busy_d;
        end
    end

    assign rq0_ack_o    = ack_q[0];
    assign rq1_ack_o    = ack_q[1];
    assign rq0_done_o   = done_q[0];
    assign rq1_done_o   = done_q[1];
    assign rq0_rd_vld_o = vld_q[0];
    assign rq1_rd_vld_o = vld_q[1];
    assign rq_rd_d_o    = rd_d_q;
    assign xf_rd_req_o  = xf_rd_req_q;
    assign xf_wr_req_o  = xf_wr_req_q;
    assign xf_addr_o    = addr_q;
    assign xf_wr_d_o    = wdat_q;
    assign arb_busy_o   = arb_busy_q;
    assign owner_o      = owner_q;

endmodule

// File: tb/tb_hram_arbiter.sv
`timescale 1ns/1ps
// Bench for hram_arbiter: directed scenarios plus randomized transactions checked against
// a cycle-count model of grant order, completion time and read-data delivery.
module tb_hram_arbiter;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rq0_rd_req = 1'b0, rq0_wr_req = 1'b0, rq1_rd_req = 1'b0, rq1_wr_req = 1'b0;
    logic [31:0] rq0_addr = '0, rq0_wr_d = '0, rq1_addr = '0, rq1_wr_d = '0;
    logic        rq0_ack, rq1_ack, rq0_done, rq1_done, rq0_rd_vld, rq1_rd_vld;
    logic [31:0] rq_rd_d;
    logic        xf_rd_req, xf_wr_req;
    logic [31:0] xf_addr, xf_wr_d;
    logic        xf_busy = 1'b0, xf_rd_rdy = 1'b0;
    logic [31:0] xf_rd_d = '0;
    logic        arb_busy, owner;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int model_owner = 1;

    // controller model configuration: busy rises rsp_d cycles after the request pulse,
    // stays high rsp_w cycles (0 = never), rd_rdy pulses rsp_r cycles after it (0 = never)
    int          rsp_d = 1, rsp_w = 0, rsp_r = 0;
    logic [31:0] rsp_data = '0;
    int          iss = -1000;

    // monitor records
    int          n_ack[2] = '{0, 0}, ack_cyc[2] = '{0, 0};
    int          n_done[2] = '{0, 0}, done_cyc[2] = '{0, 0};
    int          n_vld[2] = '{0, 0}, vld_cyc[2] = '{0, 0};
    logic [31:0] vld_dat[2];
    int          n_xwr = 0, n_xrd = 0, xreq_cyc = 0, n_busy = 0;
    logic [31:0] xreq_addr = '0, xreq_wd = '0;
    int          grants[$];

    hram_arbiter #(.START_TIMEOUT(T)) dut (
        .clk_i(clk), .reset_i(reset),
        .rq0_rd_req_i(rq0_rd_req), .rq0_wr_req_i(rq0_wr_req), .rq0_addr_i(rq0_addr), .rq0_wr_d_i(rq0_wr_d),
        .rq1_rd_req_i(rq1_rd_req), .rq1_wr_req_i(rq1_wr_req), .rq1_addr_i(rq1_addr), .rq1_wr_d_i(rq1_wr_d),
        .rq0_ack_o(rq0_ack), .rq1_ack_o(rq1_ack), .rq0_done_o(rq0_done), .rq1_done_o(rq1_done),
        .rq0_rd_vld_o(rq0_rd_vld), .rq1_rd_vld_o(rq1_rd_vld), .rq_rd_d_o(rq_rd_d),
        .xf_rd_req_o(xf_rd_req), .xf_wr_req_o(xf_wr_req), .xf_addr_o(xf_addr), .xf_wr_d_o(xf_wr_d),
        .xf_busy_i(xf_busy), .xf_rd_rdy_i(xf_rd_rdy), .xf_rd_d_i(xf_rd_d),
        .arb_busy_o(arb_busy), .owner_o(owner)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(negedge clk);
        if (xf_rd_req || xf_wr_req) iss = cyc;
        xf_busy   = (rsp_w > 0) && (cyc >= iss + rsp_d) && (cyc < iss + rsp_d + rsp_w);
        xf_rd_rdy = (rsp_r > 0) && (cyc == iss + rsp_r);
        xf_rd_d   = xf_rd_rdy ? rsp_data : ~rsp_data;
    end

    initial forever begin
        @(negedge clk);
        if (rq0_ack) begin n_ack[0]++; ack_cyc[0] = cyc; grants.push_back(0); end
        if (rq1_ack) begin n_ack[1]++; ack_cyc[1] = cyc; grants.push_back(1); end
        if (rq0_done) begin n_done[0]++; done_cyc[0] = cyc; end
        if (rq1_done) begin n_done[1]++; done_cyc[1] = cyc; end
        if (rq0_rd_vld) begin n_vld[0]++; vld_cyc[0] = cyc; vld_dat[0] = rq_rd_d; end
        if (rq1_rd_vld) begin n_vld[1]++; vld_cyc[1] = cyc; vld_dat[1] = rq_rd_d; end
        if (xf_wr_req) n_xwr++;
        if (xf_rd_req) n_xrd++;
        if (xf_wr_req || xf_rd_req) begin xreq_cyc = cyc; xreq_addr = xf_addr; xreq_wd = xf_wr_d; end
        if (arb_busy) n_busy++;
    end

    // Completion cycle for an access whose ack/request pulse is in cycle c1.
    function automatic int exp_done(input int c1, input int d, input int w);
        if (w > 0 && d >= 1 && d <= T) return c1 + d + w + 1;
        return c1 + T + 1;
    endfunction

    function automatic int exp_winner(input bit p0, input bit p1, input int own);
        if (p0 && p1) begin
`ifdef HRAM_ARB_RR_EN
            return (own == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        return p1 ? 1 : 0;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_txn(input logic r0, input logic w0, input logic r1, input logic w1,
                             input logic [31:0] a0, input logic [31:0] d0,
                             input logic [31:0] a1, input logic [31:0] d1,
                             input int d, input int w, input int r, input logic [31:0] data,
                             output int k);
        int acks, dones, i;
        rsp_d = d; rsp_w = w; rsp_r = r; rsp_data = data;
        rq0_rd_req = r0; rq0_wr_req = w0; rq0_addr = a0; rq0_wr_d = d0;
        rq1_rd_req = r1; rq1_wr_req = w1; rq1_addr = a1; rq1_wr_d = d1;
        k = cyc;
        acks  = n_ack[0] + n_ack[1];
        dones = n_done[0] + n_done[1];
        i = 0;
        while (n_ack[0] + n_ack[1] == acks && i < 8) begin tick(); i++; end
        rq0_rd_req = 1'b0; rq0_wr_req = 1'b0; rq1_rd_req = 1'b0; rq1_wr_req = 1'b0;
        i = 0;
        while (n_done[0] + n_done[1] == dones && i < 60) begin tick(); i++; end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_checks++; if ({rq0_ack, rq1_ack, rq0_done, rq1_done, rq0_rd_vld, rq1_rd_vld, xf_rd_req, xf_wr_req} !== 8'h00) begin n_fail++; $display("FAIL reset_pulses: got %b exp 0", {rq0_ack, rq1_ack, rq0_done, rq1_done, rq0_rd_vld, rq1_rd_vld, xf_rd_req, xf_wr_req}); end
        n_checks++; if (xf_addr !== 32'h0 || xf_wr_d !== 32'h0) begin n_fail++; $display("FAIL reset_xf_bus: got addr %h wd %h exp 0", xf_addr, xf_wr_d); end
        n_checks++; if (rq_rd_d !== 32'h0) begin n_fail++; $display("FAIL reset_rd_d: got %h exp 0", rq_rd_d); end
        n_checks++; if (arb_busy !== 1'b0 || owner !== 1'b1) begin n_fail++; $display("FAIL reset_state: got busy %b owner %b exp 0/1", arb_busy, owner); end
        reset = 1'b0;
        repeat (2) tick();
        n_checks++; if (arb_busy !== 1'b0 || n_ack[0] + n_ack[1] != 0) begin n_fail++; $display("FAIL idle_after_reset: got busy %b acks %0d exp 0/0", arb_busy, n_ack[0] + n_ack[1]); end
        model_owner = 1;
    endtask

    task automatic test_single_write();
        int k, s_ack, s_done, s_xwr, s_xrd;
        s_ack = n_ack[0]; s_done = n_done[0]; s_xwr = n_xwr; s_xrd = n_xrd;
        drive_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 32'h0, 2, 10, 0, 32'h0, k);
        repeat (4) tick();
        n_checks++; if (n_ack[0] - s_ack != 1 || ack_cyc[0] != k + 1) begin n_fail++; $display("FAIL wr_ack: got n=%0d cyc=%0d exp 1 at %0d", n_ack[0] - s_ack, ack_cyc[0], k + 1); end
        n_checks++; if (n_xwr - s_xwr != 1 || n_xrd != s_xrd || xreq_cyc != k + 1) begin n_fail++; $display("FAIL wr_xreq: got wr=%0d rd=%0d cyc=%0d exp 1/0 at %0d", n_xwr - s_xwr, n_xrd - s_xrd, xreq_cyc, k + 1); end
        n_checks++; if (xreq_addr !== 32'h10 || xreq_wd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_bus: got %h/%h exp 00000010/deadbeef", xreq_addr, xreq_wd); end
        n_checks++; if (n_done[0] - s_done != 1 || done_cyc[0] != exp_done(k + 1, 2, 10)) begin n_fail++; $display("FAIL wr_done: got n=%0d cyc=%0d exp 1 at %0d", n_done[0] - s_done, done_cyc[0], exp_done(k + 1, 2, 10)); end
        n_checks++; if (owner !== 1'b0 || arb_busy !== 1'b0) begin n_fail++; $display("FAIL wr_final: got owner %b busy %b exp 0/0", owner, arb_busy); end
        model_owner = 0;
    endtask

    task automatic test_single_read();
        int k, s0, s_ack1, s_done1, s_vld1;
        s0 = n_ack[0] + n_done[0] + n_vld[0];
        s_ack1 = n_ack[1]; s_done1 = n_done[1]; s_vld1 = n_vld[1];
        drive_txn(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h20, 32'h0, 2, 6, 4, 32'h12345678, k);
        n_checks++; if (n_ack[1] - s_ack1 != 1 || ack_cyc[1] != k + 1 || xreq_addr !== 32'h20) begin n_fail++; $display("FAIL rd_ack: got n=%0d cyc=%0d addr=%h exp 1 at %0d addr 20", n_ack[1] - s_ack1, ack_cyc[1], xreq_addr, k + 1); end
        n_checks++; if (n_vld[1] - s_vld1 != 1 || vld_cyc[1] != k + 6) begin n_fail++; $display("FAIL rd_vld: got n=%0d cyc=%0d exp 1 at %0d", n_vld[1] - s_vld1, vld_cyc[1], k + 6); end
        n_checks++; if (vld_dat[1] !== 32'h12345678) begin n_fail++; $display("FAIL rd_data: got %h exp 12345678", vld_dat[1]); end
        n_checks++; if (n_done[1] - s_done1 != 1 || done_cyc[1] != exp_done(k + 1, 2, 6)) begin n_fail++; $display("FAIL rd_done: got n=%0d cyc=%0d exp 1 at %0d", n_done[1] - s_done1, done_cyc[1], exp_done(k + 1, 2, 6)); end
        n_checks++; if (n_ack[0] + n_done[0] + n_vld[0] != s0) begin n_fail++; $display("FAIL rd_port0_quiet: got %0d port0 pulses exp 0", n_ack[0] + n_done[0] + n_vld[0] - s0); end
        model_owner = 1;
    endtask

    task automatic test_timeout();
        int k, s_busy;
        s_busy = n_busy;
        drive_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0, 32'h0, 1, 0, 0, 32'h0, k);
        n_checks++; if (done_cyc[0] - ack_cyc[0] != T + 1 || ack_cyc[0] != k + 1) begin n_fail++; $display("FAIL timeout_done: got ack %0d done %0d exp ack %0d done %0d", ack_cyc[0], done_cyc[0], k + 1, k + T + 2); end
        n_checks++; if (arb_busy !== 1'b0 || n_busy - s_busy != T + 1) begin n_fail++; $display("FAIL timeout_busy: got busy %b span %0d exp 0 span %0d", arb_busy, n_busy - s_busy, T + 1); end
        model_owner = 0;
    endtask

    task automatic test_rd_wr_together();
        int k, s_xwr, s_xrd, s_vld, s_done;
        s_xwr = n_xwr; s_xrd = n_xrd; s_vld = n_vld[0] + n_vld[1]; s_done = n_done[0];
        drive_txn(1'b1, 1'b1, 1'b0, 1'b0, 32'h80, 32'hA5A50F0F, 32'h0, 32'h0, 1, 3, 2, 32'h55AA55AA, k);
        n_checks++; if (n_xwr - s_xwr != 1 || n_xrd - s_xrd != 0) begin n_fail++; $display("FAIL rdwr_op: got wr=%0d rd=%0d exp 1/0", n_xwr - s_xwr, n_xrd - s_xrd); end
        n_checks++; if (n_vld[0] + n_vld[1] != s_vld) begin n_fail++; $display("FAIL rdwr_no_vld: got %0d rd_vld exp 0", n_vld[0] + n_vld[1] - s_vld); end
        n_checks++; if (n_done[0] - s_done != 1 || done_cyc[0] != exp_done(k + 1, 1, 3) || xreq_wd !== 32'hA5A50F0F) begin n_fail++; $display("FAIL rdwr_done: got n=%0d cyc=%0d wd=%h exp 1 at %0d wd a5a50f0f", n_done[0] - s_done, done_cyc[0], xreq_wd, exp_done(k + 1, 1, 3)); end
        model_owner = 0;
    endtask

    task automatic test_reset_mid_access();
        int k, i, a0, s_done;
        logic [31:0] dat;
        dat = $urandom | 32'h1;
        rsp_d = 1; rsp_w = 10; rsp_r = 2; rsp_data = dat;
        rq0_rd_req = 1'b1; rq0_addr = 32'h40; rq0_wr_d = 32'hCAFEF00D;
        k = cyc; a0 = n_ack[0]; s_done = n_done[0] + n_done[1];
        i = 0;
        while (n_ack[0] == a0 && i < 8) begin tick(); i++; end
        rq0_rd_req = 1'b0;
        while (cyc < k + 6) tick();
        n_checks++; if (rq_rd_d !== dat || arb_busy !== 1'b1 || owner !== 1'b0) begin n_fail++; $display("FAIL mid_pre: got rd_d %h busy %b owner %b exp %h/1/0", rq_rd_d, arb_busy, owner, dat); end
        reset = 1'b1; rsp_w = 0; rsp_r = 0;
        tick();
        n_checks++; if ({rq0_ack, rq1_ack, rq0_done, rq1_done, rq0_rd_vld, rq1_rd_vld, xf_rd_req, xf_wr_req} !== 8'h00) begin n_fail++; $display("FAIL mid_pulses: got %b exp 0", {rq0_ack, rq1_ack, rq0_done, rq1_done, rq0_rd_vld, rq1_rd_vld, xf_rd_req, xf_wr_req}); end
        n_checks++; if (xf_addr !== 32'h0 || xf_wr_d !== 32'h0 || rq_rd_d !== 32'h0) begin n_fail++; $display("FAIL mid_regs: got %h %h %h exp 0", xf_addr, xf_wr_d, rq_rd_d); end
        n_checks++; if (owner !== 1'b1 || arb_busy !== 1'b0) begin n_fail++; $display("FAIL mid_state: got owner %b busy %b exp 1/0", owner, arb_busy); end
        reset = 1'b0;
        repeat (12) tick();
        n_checks++; if (n_done[0] + n_done[1] != s_done || arb_busy !== 1'b0) begin n_fail++; $display("FAIL mid_no_done: got %0d done busy %b exp 0/0", n_done[0] + n_done[1] - s_done, arb_busy); end
        model_owner = 1;
    endtask

    task automatic test_contention();
        int g0, s_done, i, own, e;
        g0 = grants.size(); s_done = n_done[0] + n_done[1];
        rsp_d = 1; rsp_w = 1; rsp_r = 0;
        rq0_wr_req = 1'b1; rq0_addr = 32'h100; rq0_wr_d = 32'h0;
        rq1_wr_req = 1'b1; rq1_addr = 32'h200; rq1_wr_d = 32'h1;
        i = 0;
        while (grants.size() - g0 < 4 && i < 100) begin tick(); i++; end
        rq0_wr_req = 1'b0; rq1_wr_req = 1'b0;
        i = 0;
        while (n_done[0] + n_done[1] - s_done < 4 && i < 40) begin tick(); i++; end
        repeat (3) tick();
        n_checks++; if (grants.size() - g0 != 4) begin n_fail++; $display("FAIL cont_count: got %0d grants exp 4", grants.size() - g0); end
        own = model_owner;
        for (int j = 0; j < 4; j++) begin
            e = exp_winner(1'b1, 1'b1, own);
            n_checks++; if (g0 + j < grants.size() && grants[g0 + j] != e) begin n_fail++; $display("FAIL cont_grant%0d: got port %0d exp %0d", j, grants[g0 + j], e); end
            own = e;
        end
        n_checks++; if (int'(owner) != own || xreq_addr !== (own == 1 ? 32'h200 : 32'h100)) begin n_fail++; $display("FAIL cont_owner: got owner %b addr %h exp %0d", owner, xreq_addr, own); end
        model_owner = own;
    endtask

    task automatic test_random(input int n);
        for (int t = 0; t < n; t++) begin
            bit p0, p1, r0, w0, r1, w1, ew, ev;
            int sel, win, d, w, r, k, ed, s_xwr, s_xrd, s_busy;
            int s_ack[2], s_done[2], s_vld[2];
            logic [31:0] a0, d0, a1, d1, data, ea, ewd;
            sel = $urandom_range(0, 2);
            p0 = (sel != 1); p1 = (sel != 0);
            sel = $urandom_range(0, 2); r0 = p0 && (sel != 1); w0 = p0 && (sel != 0);
            sel = $urandom_range(0, 2); r1 = p1 && (sel != 1); w1 = p1 && (sel != 0);
            a0 = $urandom; d0 = $urandom; a1 = $urandom; d1 = $urandom; data = $urandom;
            if ($urandom_range(0, 4) == 0) begin
                d = 1; w = 0; r = $urandom_range(1, T);
            end else begin
                d = $urandom_range(1, T); w = $urandom_range(1, 6); r = $urandom_range(0, d + w);
            end
            win = exp_winner(p0, p1, model_owner);
            ew  = (win == 1) ? w1 : w0;
            ea  = (win == 1) ? a1 : a0;
            ewd = (win == 1) ? d1 : d0;
            ev  = !ew && (r > 0);
            s_ack = n_ack; s_done = n_done; s_vld = n_vld; s_xwr = n_xwr; s_xrd = n_xrd; s_busy = n_busy;
            drive_txn(r0, w0, r1, w1, a0, d0, a1, d1, d, w, r, data, k);
            ed = exp_done(k + 1, d, w);
            n_checks++; if (n_ack[win] - s_ack[win] != 1 || n_ack[1 - win] != s_ack[1 - win] || ack_cyc[win] != k + 1) begin n_fail++; $display("FAIL rnd%0d_ack: got win=%0d lose=%0d cyc=%0d exp port %0d at %0d", t, n_ack[win] - s_ack[win], n_ack[1 - win] - s_ack[1 - win], ack_cyc[win], win, k + 1); end
            n_checks++; if (int'(owner) != win) begin n_fail++; $display("FAIL rnd%0d_owner: got %b exp %0d", t, owner, win); end
            n_checks++; if (n_xwr - s_xwr != (ew ? 1 : 0) || n_xrd - s_xrd != (ew ? 0 : 1)) begin n_fail++; $display("FAIL rnd%0d_op: got wr=%0d rd=%0d exp wr=%b", t, n_xwr - s_xwr, n_xrd - s_xrd, ew); end
            n_checks++; if (xreq_addr !== ea || xreq_wd !== ewd) begin n_fail++; $display("FAIL rnd%0d_bus: got %h/%h exp %h/%h", t, xreq_addr, xreq_wd, ea, ewd); end
            n_checks++; if (n_done[win] - s_done[win] != 1 || n_done[1 - win] != s_done[1 - win] || done_cyc[win] != ed) begin n_fail++; $display("FAIL rnd%0d_done: got n=%0d cyc=%0d exp 1 at %0d", t, n_done[win] - s_done[win], done_cyc[win], ed); end
            n_checks++; if (n_vld[win] - s_vld[win] != (ev ? 1 : 0) || n_vld[1 - win] != s_vld[1 - win]) begin n_fail++; $display("FAIL rnd%0d_vld_cnt: got %0d exp %b", t, n_vld[win] - s_vld[win], ev); end
            if (ev) begin
                n_checks++; if (vld_cyc[win] != k + r + 2 || vld_dat[win] !== data) begin n_fail++; $display("FAIL rnd%0d_vld: got cyc %0d data %h exp %0d %h", t, vld_cyc[win], vld_dat[win], k + r + 2, data); end
            end
            n_checks++; if (n_busy - s_busy != ed - k - 1) begin n_fail++; $display("FAIL rnd%0d_busy_span: got %0d exp %0d", t, n_busy - s_busy, ed - k - 1); end
            model_owner = win;
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_timeout();
        test_rd_wr_together();
        test_reset_mid_access();
        test_contention();
        test_random(30);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
